// File: rtl/fht_wr_control.sv
// Write-side sequencer of the FHT stage loop: turns butterfly results into bank write
// addresses and write enables for one stage. Optional watchdog: define FHT_WR_TIMEOUT_EN.
module fht_wr_control #(
   parameter int A_BIT  = 8,
   parameter int TO_BIT = 4
) (
   input  logic             iCLK,
   input  logic             iRESET,
   input  logic             iSTART,
   input  logic             iVALID,
   input  logic             iSOURCE_DATA,
   input  logic             iST_LAST,
   input  logic [3:0]       iDIV_2,
   output logic [A_BIT-1:0] oADDR_WR,
   output logic [A_BIT-1:0] oADDR_WR_BIAS,
   output logic             oWE_A,
   output logic             oWE_B,
   output logic             oBUSY,
   output logic             oDONE,
   output logic             oERR
);

   typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

   localparam logic [A_BIT-1:0] CNT_MAX = '1;

   state_t           state, state_nxt;
   logic [A_BIT-1:0] cnt;
   logic [A_BIT-1:0] bias_mask;
   logic             src_q;
   logic             last_q;
   logic [3:0]       div_q;
   logic             timeout;

`ifdef FHT_WR_TIMEOUT_EN
   localparam logic [TO_BIT-1:0] WD_LAST = TO_BIT'((1 << TO_BIT) - 2);

   logic [TO_BIT-1:0] wd;

   // Watchdog only runs while waiting for results; the edge that would bring it to
   // its terminal count aborts the stage instead.
   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET)
         wd <= '0;
      else if (iSTART || iVALID || state != WRITE)
         wd <= '0;
      else
         wd <= wd + 1'b1;
   end

   assign timeout = (state == WRITE) && !iSTART && !iVALID && (wd == WD_LAST);
`else
   logic [TO_BIT-1:0] unused_wd;

   assign unused_wd = '0;
   assign timeout   = 1'b0;
`endif

   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (iSTART) begin
         state_nxt = WRITE;
      end else begin
         case (state)
            IDLE:    state_nxt = IDLE;
            WRITE: begin
               if (iVALID && cnt == CNT_MAX)
                  state_nxt = DONE;
               else if (timeout)
                  state_nxt = IDLE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Bias partner differs in bit div_2-1; out-of-range div_2 or the last stage means no flip.
   always_comb begin
      bias_mask = '0;
      for (int i = 0; i < A_BIT; i++) begin
         if (!last_q && int'(div_q) == i + 1)
            bias_mask[i] = 1'b1;
      end
   end

   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET) begin
         cnt           <= '0;
         src_q         <= 1'b0;
         last_q        <= 1'b0;
         div_q         <= '0;
         oADDR_WR      <= '0;
         oADDR_WR_BIAS <= '0;
         oWE_A         <= 1'b0;
         oWE_B         <= 1'b0;
         oDONE         <= 1'b0;
         oERR          <= 1'b0;
      end else begin
         oWE_A <= 1'b0;
         oWE_B <= 1'b0;
         oDONE <= 1'b0;
         if (iSTART) begin
            cnt    <= '0;
            src_q  <= iSOURCE_DATA;
            last_q <= iST_LAST;
            div_q  <= iDIV_2;
            oERR   <= 1'b0;
         end else if (state == WRITE && iVALID) begin
            oWE_A         <= src_q;
            oWE_B         <= ~src_q;
            oADDR_WR      <= cnt;
            oADDR_WR_BIAS <= cnt ^ bias_mask;
            oDONE         <= (cnt == CNT_MAX);
            cnt           <= cnt + 1'b1;
         end else if (iVALID || timeout) begin
            oERR <= 1'b1;
         end
      end
   end

   assign oBUSY = (state == WRITE);

endmodule
